// File: rtl/mdu_ctrl_pkg.sv
// Shared multiply/divide definitions: mdOp encodings, default latencies and op decode helpers.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  // Multiply-class ops share MUL_LAT; the accumulate forms only decode when built in.
  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage multiply/divide bus: operation request from the pipeline, status and HI/LO back.
interface mdu_ctrl_if;
  logic [3:0]  mdOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        cancel;
  logic        busy;
  logic        inUse;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output mdOp, srcA, srcB, cancel, input busy, inUse, hi, lo);
  modport slave  (input mdOp, srcA, srcB, cancel, output busy, inUse, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// Combinational 64-bit multiply/divide result calculator; write_en is low when HI/LO must stay unchanged.
// Accumulating ops are only decoded when MDU_MADD_EN is defined.
module mdu_core
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] result,
  output logic        write_en
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] squot;
  logic [31:0] srem;

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_mag = a[31] ? -a : a;
  assign b_mag = b[31] ? -b : b;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign squot = (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign srem  = a[31] ? -r_mag : r_mag;

  always_comb begin
    result   = hilo;
    write_en = 1'b0;
    case (op)
      OP_MULT:  begin result = sprod; write_en = 1'b1; end
      OP_MULTU: begin result = uprod; write_en = 1'b1; end
      OP_DIV: begin
        result   = {srem, squot};
        write_en = (b != 32'd0);
      end
      OP_DIVU: begin
        result   = (b == 32'd0) ? hilo : {a % b, a / b};
        write_en = (b != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin result = hilo + sprod; write_en = 1'b1; end
      OP_MADDU: begin result = hilo + uprod; write_en = 1'b1; end
      OP_MSUB:  begin result = hilo - sprod; write_en = 1'b1; end
      OP_MSUBU: begin result = hilo - uprod; write_en = 1'b1; end
`endif
      default: begin
        result   = hilo;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; counts a fixed latency per op and reports busy/inUse.
// Define MDU_MADD_EN to accept the MADD/MADDU/MSUB/MSUBU family.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_e      state_q;
  state_e      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        start;
  logic        finish;
  logic        core_we;
  logic [63:0] core_res;

  assign start  = (is_mul_op(bus.mdOp) || is_div_op(bus.mdOp)) && (state_q == ST_IDLE) && !bus.cancel;
  assign finish = (state_q == ST_BUSY) && (cnt_q == 4'd1);

  assign bus.busy  = (state_q == ST_BUSY);
  assign bus.inUse = (state_q == ST_BUSY) || start;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  mdu_core u_core (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hilo     ({hi_q, lo_q}),
    .result   (core_res),
    .write_en (core_we)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_BUSY;
      ST_BUSY: if (finish) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // MT* and new starts are only honoured while idle; in-flight ops ignore cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q - 4'd1;
      if (finish && core_we) begin
        hi_q <= core_res[63:32];
        lo_q <= core_res[31:0];
      end
    end else if (start) begin
      op_q  <= bus.mdOp;
      a_q   <= bus.srcA;
      b_q   <= bus.srcB;
      cnt_q <= is_div_op(bus.mdOp) ? DIV_CNT : MUL_CNT;
    end else if (!bus.cancel && bus.mdOp == OP_MTHI) begin
      hi_q <= bus.srcA;
    end else if (!bus.cancel && bus.mdOp == OP_MTLO) begin
      lo_q <= bus.srcA;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline; it sits beside the ALU.
- Owns the HI/LO registers.
- Latches operands at start and counts the fixed operation latency.
- Reports busy/in-use so the hazard unit can stall MF*/MT*/MD instructions in D.
- Honours exception cancel from the M stage: an instruction that faults, or is flushed by an interrupt, must not start.

Parameters:
MUL_LAT, 5, busy cycles for MULT/MULTU (and MADD* family when enabled); legal range 1..15
DIV_LAT, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
mdOp  input  4  E-stage operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 treated as NONE
srcA  input  32  rs operand (forwarded)
srcB  input  32  rt operand (forwarded)
cancel  input  1  exception/interrupt flush this cycle; suppresses any E-stage mdOp
busy  output  1  registered; high while an operation is in flight
inUse  output  1  combinational: busy OR a start is being accepted this cycle (hazard unit stall term)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (synchronous, active-high):
  - busy=0, counter=0, hi=0, lo=0, latched operands=0.
  - Reset asserted mid-operation aborts the operation; no HI/LO write occurs.
- Accept rule: start = (mdOp is MULT..DIVU, or MADD..MSUBU when enabled) AND !busy AND !cancel.
- Start at edge T:
  - Latch op, srcA and srcB.
  - counter loads MUL_LAT or DIV_LAT.
  - busy=1 from T+1.
- Counting:
  - counter decrements each cycle while busy.
  - On the edge where counter==1: busy clears and HI/LO are written with the result.
  - Result visible in the cycle busy first reads 0.
  - Busy is therefore high for exactly LAT cycles.
- MTHI/MTLO (!busy, !cancel):
  - Write hi or lo with srcA at the next edge; no busy.
  - While busy: ignored, state unchanged; the hazard unit must prevent this.
- mdOp arriving while busy: ignored; never queued.
- cancel:
  - Blocks a start or MT* in the same cycle.
  - Does not abort an in-flight operation; it completes normally (in-flight ops precede the faulting instruction).
- Arithmetic:
  - MULT: {hi,lo} = 64-bit signed srcA*srcB.
  - MULTU: {hi,lo} = unsigned product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - DIV/DIVU with srcB==0: hi/lo unchanged at completion; busy still runs the full DIV_LAT.
- inUse = busy | start; purely combinational from the inputs and busy.

Optional Feature:
MDU_MADD_EN
- Defined:
  - ops 7-10 are legal and use MUL_LAT.
  - MADD: {hi,lo} += signed product. MADDU: {hi,lo} += unsigned product.
  - MSUB: {hi,lo} -= signed product. MSUBU: {hi,lo} -= unsigned product.
  - All are 64-bit modulo; the {hi,lo} operand is sampled at start.
- Undefined: ops 7-10 decode as NONE and never assert busy or inUse.

Decomposition:
- Shared package/header (alongside the ALU op defines):
  - mdOp encodings.
  - default MUL_LAT and DIV_LAT.
- Sub-module mdu_core: pure combinational 64-bit result calculator taking op, latched operands and current {hi,lo}.
- mdu_ctrl keeps the counter, busy, HI/LO and the accept logic.

Test Plan:
- MULT srcA=0xFFFFFFFE (-2), srcB=3, no cancel -> inUse=1 in the issue cycle; busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU srcA=7, srcB=2 -> busy for 10 cycles; then lo=3, hi=1. DIV srcA=-7, srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTLO srcA=0x1234 -> lo=0x1234 the next cycle; busy stays 0. Then MULT issued with cancel=1 -> busy stays 0 and hi/lo unchanged.
- Start DIV 100/0, then issue MULT and MTHI during busy -> both ignored; after 10 cycles hi/lo still hold their prior values.
- Start MULT 5*5; assert reset in busy cycle 3 -> next cycle busy=0, hi=lo=0, and no later write.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0 after 5 cycles. Without the macro: op 8 -> busy never asserts.
